sm83_cb_seq: RTL

CB-prefix micro-sequencer for the SM83 core. It sits directly upstream of the ALU. It accepts one CB opcode byte from the main decoder and produces the ALU control line for each cycle of the instruction: bit-mask load, operand load through the shifter, and result output. It also drives register-file and memory strobes for operand fetch and write-back. It covers rotate/shift/SWAP (00–3F), BIT (40–7F), RES (80–BF) and SET (C0–FF).

---
 rtl/alu_pkg.sv | 100 ++++++++++
 rtl/sm83_cb_line_rom.sv | 50 +++++
 rtl/sm83_cb_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/CB-sequencer definitions: control-word layout, enable/load
// encodings, shifter mode table, carry-chain bundles, sequencer states and
// a reference result function for the CB operations.
package alu_pkg;

  // ALU output-enable source
  typedef enum logic [1:0] {NO_OE = 2'd0, BS_OE = 2'd1, SH_OE = 2'd2, RES_OE = 2'd3} oe_e;

  // ALU input latch control
  typedef enum logic {NO_LD = 1'b0, BUS_LD = 1'b1} ld_e;

  // Shifter mode; NO_SH passes the operand straight through
  typedef enum logic [3:0] {
    NO_SH   = 4'd0,
    SH_RLC  = 4'd1,
    SH_RRC  = 4'd2,
    SH_RL   = 4'd3,
    SH_RR   = 4'd4,
    SH_SLA  = 4'd5,
    SH_SRA  = 4'd6,
    SH_SWAP = 4'd7,
    SH_SRL  = 4'd8
  } sh_e;

  // Carry-chain control bundle
  typedef struct packed {
    logic r;
    logic s;
    logic v;
    logic ne;
    logic ci;
  } cc_t;

  // One ALU control word per cycle
  typedef struct packed {
    logic [2:0] bs;
    oe_e        oe;
    ld_e        la;
    ld_e        lb;
    logic       l;
    logic       h;
    sh_e        sh;
    cc_t        cc;
  } alu_line_t;

  localparam cc_t CC_PASS = '{r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0};
  localparam cc_t CC_AND  = '{r: 1'b0, s: 1'b1, v: 1'b0, ne: 1'b0, ci: 1'b1};
  localparam cc_t CC_ANDN = '{r: 1'b0, s: 1'b1, v: 1'b0, ne: 1'b1, ci: 1'b1};
  localparam cc_t CC_OR   = '{r: 1'b1, s: 1'b1, v: 1'b0, ne: 1'b0, ci: 1'b0};

  localparam alu_line_t IDLE_LINE = '{bs: 3'd0, oe: NO_OE, la: NO_LD, lb: NO_LD,
                                      l: 1'b0, h: 1'b0, sh: NO_SH, cc: CC_PASS};

  // Shift mode selected by opcode[5:3] in the 00-3F range
  localparam sh_e SH_MODE [8] = '{SH_RLC, SH_RRC, SH_RL, SH_RR,
                                  SH_SLA, SH_SRA, SH_SWAP, SH_SRL};

  // CB opcode group, opcode[7:6]
  typedef enum logic [1:0] {GRP_SHIFT = 2'd0, GRP_BIT = 2'd1, GRP_RES = 2'd2, GRP_SET = 2'd3} cb_group_e;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MASK   = 3'd1,
    ST_MRD    = 3'd2,
    ST_LOAD   = 3'd3,
    ST_RESULT = 3'd4,
    ST_MWR    = 3'd5
  } cb_state_e;

  // Result byte of a CB operation. The F carry is not visible here, so RL/RR
  // rotate in 0; the value is used only as (HL) write-back data and as the
  // ALU bus value in RESULT.
  function automatic logic [7:0] cb_result(input cb_group_e grp, input logic [2:0] b,
                                           input logic [7:0] x);
    logic [7:0] mask;
    logic [7:0] r;
    mask = 8'd1 << b;
    r    = x;
    case (grp)
      GRP_BIT: r = x & mask;
      GRP_RES: r = x & ~mask;
      GRP_SET: r = x | mask;
      default: begin
        case (b)
          3'd0:    r = {x[6:0], x[7]};
          3'd1:    r = {x[0], x[7:1]};
          3'd2:    r = {x[6:0], 1'b0};
          3'd3:    r = {1'b0, x[7:1]};
          3'd4:    r = {x[6:0], 1'b0};
          3'd5:    r = {x[7], x[7:1]};
          3'd6:    r = {x[3:0], x[7:4]};
          default: r = {1'b0, x[7:1]};
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sm83_cb_line_rom.sv
// ALU control-word table: pure function of sequencer state, opcode group
// and bit/shift index.
module sm83_cb_line_rom
  import alu_pkg::*;
(
  input  cb_state_e  state,
  input  cb_group_e  group,
  input  logic [2:0] b,
  output alu_line_t  line
);

  cc_t cc;

  // Decode the control word for the current state
  always_comb begin
    case (group)
      GRP_BIT: cc = CC_AND;
      GRP_RES: cc = CC_ANDN;
      GRP_SET: cc = CC_OR;
      default: cc = CC_PASS;
    endcase
    line = IDLE_LINE;
    case (state)
      ST_MASK: begin
        line.bs = b;
        line.oe = BS_OE;
        line.lb = BUS_LD;
      end
      ST_LOAD: begin
        line.oe = SH_OE;
        line.la = BUS_LD;
        line.lb = NO_LD;
        line.l  = 1'b1;
        line.h  = 1'b0;
        line.sh = (group == GRP_SHIFT) ? SH_MODE[b] : NO_SH;
        line.cc = cc;
      end
      ST_RESULT: begin
        line.oe = RES_OE;
        line.la = NO_LD;
        line.lb = NO_LD;
        line.l  = 1'b0;
        line.h  = 1'b1;
        line.cc = cc;
      end
      default: line = IDLE_LINE;
    endcase
  end

endmodule

// File: rtl/sm83_cb_seq.sv
// CB-prefix micro-sequencer: steps one CB opcode through MASK/MRD/LOAD/
// RESULT/MWR and drives the ALU control word, operand bus and strobes.
// Define SM83_CB_HL_EN to support (HL) operands; otherwise register 6 is
// rejected with an illegal pulse and the memory strobes are tied low.
//
// Handshake: an opcode is taken on a rising edge where op_valid && op_ready;
// op_ready is high only in IDLE (and not during reset or the cycle after a
// rejected opcode). The source holds op_valid/opcode until taken.
module sm83_cb_seq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [7:0] opcode,
  output alu_line_t  alu_line,
  output logic [7:0] alu_op,
  output logic [2:0] reg_sel,
  input  logic [7:0] reg_rdata,
  output logic       reg_we,
  output logic       flags_we,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       done,
  output logic       illegal,
  output cb_state_e  dbg_state
);

`ifdef SM83_CB_HL_EN
  localparam logic HL_EN = 1'b1;
`else
  localparam logic HL_EN = 1'b0;
`endif

  cb_state_e  state_q;
  cb_group_e  grp_q;
  logic [2:0] b_q;
  logic [2:0] reg_q;
  logic [7:0] mem_q;
  logic [7:0] res_q;
  logic       illegal_q;

  logic       accept;
  logic       hl_q;
  logic       need_mwr;
  logic [7:0] operand;
  alu_line_t  rom_line;

  assign accept   = op_valid && op_ready;
  assign hl_q     = HL_EN && (reg_q == 3'd6);
  assign need_mwr = hl_q && (grp_q != GRP_BIT);
  assign operand  = hl_q ? mem_q : reg_rdata;

  sm83_cb_line_rom u_line_rom (
    .state (state_q),
    .group (grp_q),
    .b     (b_q),
    .line  (rom_line)
  );

  // Sequencer FSM: latches opcode fields, captures (HL) data and the result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grp_q     <= GRP_SHIFT;
      b_q       <= 3'd0;
      reg_q     <= 3'd0;
      mem_q     <= 8'd0;
      res_q     <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            grp_q <= cb_group_e'(opcode[7:6]);
            b_q   <= opcode[5:3];
            reg_q <= opcode[2:0];
            if ((opcode[2:0] == 3'd6) && !HL_EN) illegal_q <= 1'b1;
            else if (opcode[7:6] != 2'b00)      state_q   <= ST_MASK;
            else if (opcode[2:0] == 3'd6)       state_q   <= ST_MRD;
            else                                state_q   <= ST_LOAD;
          end
        end
        ST_MASK:   state_q <= hl_q ? ST_MRD : ST_LOAD;
        ST_MRD: begin
          if (mem_ack) begin
            mem_q   <= mem_rdata;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          res_q   <= cb_result(grp_q, b_q, operand);
          state_q <= ST_RESULT;
        end
        ST_RESULT: state_q <= need_mwr ? ST_MWR : ST_IDLE;
        ST_MWR:    if (mem_ack) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Operand bus: source value in LOAD, result in RESULT/MWR
  always_comb begin
    alu_op = 8'd0;
    if (reset_n) begin
      case (state_q)
        ST_LOAD:           alu_op = operand;
        ST_RESULT, ST_MWR: alu_op = res_q;
        default:           alu_op = 8'd0;
      endcase
    end
  end

  assign op_ready  = reset_n && (state_q == ST_IDLE) && !illegal_q;
  assign alu_line  = reset_n ? rom_line : IDLE_LINE;
  assign reg_sel   = reg_q;
  assign reg_we    = reset_n && (state_q == ST_RESULT) && (grp_q != GRP_BIT) && !hl_q;
  assign flags_we  = reset_n && (state_q == ST_RESULT) &&
                     ((grp_q == GRP_BIT) || (grp_q == GRP_SHIFT));
  assign done      = reset_n && (((state_q == ST_RESULT) && !need_mwr) ||
                                 ((state_q == ST_MWR) && mem_ack));
  assign illegal   = illegal_q;
  assign dbg_state = state_q;

`ifdef SM83_CB_HL_EN
  assign mem_rd = reset_n && (state_q == ST_MRD);
  assign mem_wr = reset_n && (state_q == ST_MWR);
`else
  assign mem_rd = 1'b0;
  assign mem_wr = 1'b0;
`endif

endmodule
